// File: rtl/data_split_fifo_128_if.sv
// Bus bundle for data_split_fifo_128: wide write side, narrow read side,
// threshold inputs, status flags and a debug view of the internal counters.
interface data_split_fifo_128_if #(
  parameter int WIDTH_IN   = 1024,
  parameter int WIDTH      = 128,
  parameter int DEPTH_BITS = 4,
  parameter int ADDR_BITS  = 10
);
  localparam int BEAT_BITS   = $clog2(WIDTH_IN / WIDTH);
  localparam int OCC_BITS    = DEPTH_BITS + 1;
  localparam int NARROW_BITS = OCC_BITS + BEAT_BITS;

  // Handshake: a write is taken on a rising edge when wr_en=1 and full=0, a
  // read when rd_en=1 and empty=0; full/empty are pre-edge state, and a
  // strobe presented against a set flag is dropped with no state change.
  logic                   Next_Reg;
  logic [WIDTH_IN-1:0]    din;
  logic                   wr_en;
  logic                   rd_en;
  logic [WIDTH-1:0]       dout;
  logic [ADDR_BITS:0]     M_count;
  logic                   M_Ready;
  logic [ADDR_BITS:0]     S_count;
  logic                   S_Ready;
  logic                   empty;
  logic                   full;
  logic [OCC_BITS-1:0]    dbg_occ;
  logic [BEAT_BITS-1:0]   dbg_beat;
  logic [NARROW_BITS-1:0] dbg_narrow;

  modport master (
    output Next_Reg, din, wr_en, rd_en, M_count, S_count,
    input  dout, M_Ready, S_Ready, empty, full, dbg_occ, dbg_beat, dbg_narrow
  );

  modport slave (
    input  Next_Reg, din, wr_en, rd_en, M_count, S_count,
    output dout, M_Ready, S_Ready, empty, full, dbg_occ, dbg_beat, dbg_narrow
  );
endinterface

// File: rtl/data_split_fifo_128.sv
// Wide-in / narrow-out FIFO: stores whole WIDTH_IN words and hands them out
// as WIDTH-bit beats, lowest slice first, with registered threshold flags.
module data_split_fifo_128 #(
  parameter int WIDTH_IN   = 1024,
  parameter int WIDTH      = 128,
  parameter int DEPTH_BITS = 4,
  parameter int ADDR_BITS  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  data_split_fifo_128_if.slave   bus
);
  localparam int DEPTH       = 1 << DEPTH_BITS;
  localparam int BEATS       = WIDTH_IN / WIDTH;
  localparam int BEAT_BITS   = $clog2(BEATS);
  localparam int OCC_BITS    = DEPTH_BITS + 1;
  localparam int NARROW_BITS = OCC_BITS + BEAT_BITS;
  localparam int CNT_BITS    = ADDR_BITS + 1;
  localparam int CMP_BITS    = (NARROW_BITS > CNT_BITS) ? NARROW_BITS : CNT_BITS;

  logic [WIDTH_IN-1:0]           mem [DEPTH];
  logic [DEPTH_BITS-1:0]         wr_ptr;
  logic [DEPTH_BITS-1:0]         rd_ptr;
  logic [OCC_BITS-1:0]           occ;
  logic [BEAT_BITS-1:0]          beat;
  logic [WIDTH-1:0]              dout_r;
  logic                          m_ready_r;
  logic                          s_ready_r;

  logic [NARROW_BITS-1:0]        narrow;
  logic                          full_c;
  logic                          empty_c;
  logic                          wr_acc;
  logic                          rd_acc;
  logic                          last_beat;
  logic                          clear;
  logic [BEATS-1:0][WIDTH-1:0]   head;
  logic [CMP_BITS-1:0]           narrow_ext;
  logic [CMP_BITS-1:0]           m_count_ext;
  logic [CMP_BITS-1:0]           occ_ext;
  logic [CMP_BITS-1:0]           s_count_ext;

  // Narrow beats still held: whole words times beats, minus beats already
  // consumed from the head word.
  assign narrow    = {occ, {BEAT_BITS{1'b0}}} - NARROW_BITS'(beat);
  assign full_c    = (occ == OCC_BITS'(DEPTH));
  assign empty_c   = (narrow == '0);
  assign clear     = rst | bus.Next_Reg;
  assign wr_acc    = bus.wr_en & ~full_c;
  assign rd_acc    = bus.rd_en & ~empty_c;
  assign last_beat = rd_acc & (beat == BEAT_BITS'(BEATS - 1));
  assign head      = mem[rd_ptr];

  assign narrow_ext  = CMP_BITS'(narrow);
  assign m_count_ext = CMP_BITS'(bus.M_count);
  assign occ_ext     = CMP_BITS'(occ);
  assign s_count_ext = CMP_BITS'(bus.S_count);

  always_ff @(posedge clk) begin
    if (wr_acc && !clear) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      beat   <= '0;
      dout_r <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (rd_acc) begin
        dout_r <= head[beat];
        if (last_beat) begin
          beat   <= '0;
          rd_ptr <= rd_ptr + DEPTH_BITS'(1);
        end else begin
          beat <= beat + BEAT_BITS'(1);
        end
      end
      if (wr_acc && !last_beat) begin
        occ <= occ + OCC_BITS'(1);
      end else if (!wr_acc && last_beat) begin
        occ <= occ - OCC_BITS'(1);
      end
    end
  end

  // Threshold flags use pre-edge counts, so they trail occupancy by a cycle;
  // a soft clear leaves them to recompute from the cleared counts next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_ready_r <= 1'b0;
      s_ready_r <= 1'b1;
    end else begin
      m_ready_r <= (narrow_ext >= m_count_ext);
      s_ready_r <= (occ_ext < s_count_ext);
    end
  end

  assign bus.dout       = dout_r;
  assign bus.M_Ready    = m_ready_r;
  assign bus.S_Ready    = s_ready_r;
  assign bus.full       = full_c;
  assign bus.empty      = empty_c;
  assign bus.dbg_occ    = occ;
  assign bus.dbg_beat   = beat;
  assign bus.dbg_narrow = narrow;
endmodule

// File: tb/tb_data_split_fifo_128.sv
// Directed and random stimulus for data_split_fifo_128, checked against a
// word-queue model of the FIFO.
module tb_data_split_fifo_128;
  localparam int WIDTH_IN = 1024;
  localparam int WIDTH    = 128;
  localparam int BEATS    = WIDTH_IN / WIDTH;
  localparam int DEPTH    = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  data_split_fifo_128_if bus ();

  data_split_fifo_128 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [WIDTH_IN-1:0] exp_q[$];
  int                  m_beat;
  logic [WIDTH-1:0]    m_dout;
  logic                m_mready;
  logic                m_sready;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH_IN-1:0] rand_word();
    logic [WIDTH_IN-1:0] w;
    for (int i = 0; i < WIDTH_IN / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step(input logic r, input logic nr, input logic wr, input logic rd,
                      input logic [WIDTH_IN-1:0] data);
    int pre_occ;
    int pre_narrow;
    logic pre_full;
    logic pre_empty;
    logic [WIDTH_IN-1:0] w;
    rst          = r;
    bus.Next_Reg = nr;
    bus.wr_en    = wr;
    bus.rd_en    = rd;
    bus.din      = data;
    pre_occ    = exp_q.size();
    pre_narrow = pre_occ * BEATS - m_beat;
    pre_full   = (pre_occ == DEPTH);
    pre_empty  = (pre_narrow == 0);
    if (!r) begin
      chk("full_pre", bus.full, pre_full);
      chk("empty_pre", bus.empty, pre_empty);
    end
    if (r) begin
      exp_q.delete();
      m_beat   = 0;
      m_dout   = '0;
      m_mready = 1'b0;
      m_sready = 1'b1;
    end else begin
      m_mready = (pre_narrow >= int'(bus.M_count));
      m_sready = (pre_occ < int'(bus.S_count));
      if (nr) begin
        exp_q.delete();
        m_beat = 0;
        m_dout = '0;
      end else begin
        if (rd && !pre_empty) begin
          w      = exp_q[0];
          m_dout = w[m_beat*WIDTH +: WIDTH];
          if (m_beat == BEATS - 1) begin
            void'(exp_q.pop_front());
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end
        if (wr && !pre_full) exp_q.push_back(data);
      end
    end
    @(posedge clk);
    #1;
    chk("dout", bus.dout, m_dout);
    chk("m_ready", bus.M_Ready, m_mready);
    chk("s_ready", bus.S_Ready, m_sready);
    chk("occ", bus.dbg_occ, exp_q.size());
    chk("narrow", bus.dbg_narrow, exp_q.size() * BEATS - m_beat);
    chk("empty_post", bus.empty, (exp_q.size() * BEATS - m_beat) == 0);
    chk("full_post", bus.full, exp_q.size() == DEPTH);
    rst          = 1'b0;
    bus.Next_Reg = 1'b0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic wr_word(input logic [WIDTH_IN-1:0] data);
    step(1'b0, 1'b0, 1'b1, 1'b0, data);
  endtask

  task automatic rd_beats(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH_IN-1:0] w;
    logic [WIDTH-1:0]    held;
    total        = 0;
    bad          = 0;
    m_beat       = 0;
    m_dout       = '0;
    m_mready     = 1'b0;
    m_sready     = 1'b1;
    rst          = 1'b1;
    bus.Next_Reg = 1'b0;
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.din      = '0;
    bus.M_count  = 11'd1;
    bus.S_count  = 11'd16;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_s_ready", bus.S_Ready, 1'b1);
    chk("rst_m_ready", bus.M_Ready, 1'b0);

    // One word with beat k = k, read back in slice order
    for (int k = 0; k < BEATS; k++) w[k*WIDTH +: WIDTH] = WIDTH'(k);
    wr_word(w);
    for (int k = 0; k < BEATS; k++) begin
      rd_beats(1);
      chk("beat_order", bus.dout, 128'(k));
    end
    chk("empty_after_8", bus.empty, 1'b1);

    // Fill to 16, 17th dropped, drain all 128 beats
    for (int i = 0; i < DEPTH; i++) wr_word(rand_word());
    chk("full_at_16", bus.full, 1'b1);
    wr_word(rand_word());
    chk("occ_after_drop", bus.dbg_occ, 16);
    rd_beats(DEPTH * BEATS);
    chk("empty_after_drain", bus.empty, 1'b1);

    // Write while full on the edge the head word is freed
    for (int i = 0; i < DEPTH; i++) wr_word(rand_word());
    rd_beats(BEATS - 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, rand_word());
    chk("full_wr_dropped_occ", bus.dbg_occ, 15);
    rd_beats(15 * BEATS);

    // Threshold flags
    bus.M_count = 11'd20;
    bus.S_count = 11'd3;
    wr_word(rand_word());
    wr_word(rand_word());
    idle();
    chk("m_ready_at_16", bus.M_Ready, 1'b0);
    wr_word(rand_word());
    chk("s_ready_lag", bus.S_Ready, 1'b1);
    idle();
    chk("m_ready_at_24", bus.M_Ready, 1'b1);
    chk("s_ready_at_3", bus.S_Ready, 1'b0);
    rd_beats(3 * BEATS);
    bus.M_count = 11'd1;
    bus.S_count = 11'd16;

    // Soft clear mid-word
    for (int i = 0; i < 3; i++) wr_word(rand_word());
    rd_beats(5);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("nr_empty", bus.empty, 1'b1);
    chk("nr_dout", bus.dout, 128'd0);
    chk("nr_narrow", bus.dbg_narrow, 0);
    idle();
    w = rand_word();
    wr_word(w);
    rd_beats(1);
    chk("nr_beat0", bus.dout, w[WIDTH-1:0]);
    rd_beats(BEATS - 1);

    // Read strobe held on an empty buffer
    held = bus.dout;
    rd_beats(10);
    chk("empty_rd_dout", bus.dout, held);
    chk("empty_rd_beat", bus.dbg_beat, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 40) == 0) begin
        bus.M_count = 11'($urandom_range(0, 130));
        bus.S_count = 11'($urandom_range(0, 17));
      end
      step(1'b0, $urandom_range(0, 80) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, rand_word());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_split_fifo_128.md
DATA_SPLIT_FIFO_128 -- requirements
Module: data_split_fifo_128

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
- WIDTH_IN, 1024, wide input word width.
- WIDTH, 128, narrow output beat width; WIDTH_IN/WIDTH = 8 beats per wide word.
- DEPTH_BITS, 4, log2 of wide-word storage depth (16 words).
- ADDR_BITS, 10, threshold port width is ADDR_BITS+1.

REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk, in, 1, sole clock; all logic on its rising edge.
- rst, in, 1, synchronous active-high reset.
- Next_Reg, in, 1, synchronous soft clear between layers.
- din, in, WIDTH_IN, wide write data.
- wr_en, in, 1, write strobe.
- rd_en, in, 1, narrow read strobe.
- dout, out, WIDTH, narrow read data.
- M_count, in, ADDR_BITS+1, back-side threshold in narrow beats.
- M_Ready, out, 1, registered: enough narrow beats stored.
- S_count, in, ADDR_BITS+1, front-side threshold in wide words.
- S_Ready, out, 1, registered: room to accept wide words.
- empty, out, 1, no narrow beats available.
- full, out, 1, no free wide-word slot.

Function
REQ-003 Storage SHALL be a circular buffer of 2^DEPTH_BITS wide words with write pointer, read pointer, and a 3-bit beat index.
REQ-004 A write SHALL be accepted on a clock edge with wr_en=1 and full=0; wr_en=1 while full=1 SHALL be dropped with no state change.
REQ-005 A read SHALL be accepted on a clock edge with rd_en=1 and empty=0; rd_en=1 while empty=1 SHALL be ignored, with dout holding its value.
REQ-006 Beat order SHALL be: beat k of a wide word = din[128*k+127 : 128*k], k = 0..7, lowest slice first.
REQ-007 Read latency SHALL be one cycle: dout is registered and takes the selected beat on the edge where the read is accepted; dout holds between reads.
REQ-008 On each accepted read the beat index SHALL increment; at beat 7 it SHALL wrap to 0 and the read pointer SHALL advance, freeing that wide slot.
REQ-009 Occupancy SHALL be tracked in wide words (0..2^DEPTH_BITS). full = (occupancy == 2^DEPTH_BITS).
REQ-010 Narrow count SHALL equal occupancy*8 - beat index. empty = (narrow count == 0). Both full and empty are combinational from registered state.
REQ-011 A simultaneous accepted write and accepted last-beat read SHALL leave occupancy unchanged. full and empty SHALL be evaluated from pre-edge state, so a write while full is dropped even if the same-edge read frees a slot.
REQ-012 M_Ready SHALL be updated every cycle as M_Ready <= (narrow count >= M_count), comparing zero-extended unsigned values.
REQ-013 S_Ready SHALL be updated every cycle as S_Ready <= (occupancy < S_count), unsigned.
REQ-014 M_Ready and S_Ready SHALL use the pre-edge count, so they lag occupancy by one cycle.
REQ-015 Pointers SHALL wrap modulo 2^DEPTH_BITS with no special handling.

Reset
REQ-016 rst=1 SHALL clear pointers, occupancy, beat index and dout to 0, and set M_Ready=0 and S_Ready=1. Memory contents are don't-care.
REQ-017 Next_Reg=1 SHALL clear pointers, occupancy, beat index and dout exactly as rst does. M_Ready and S_Ready SHALL recompute per REQ-012/013 on the following edge.
REQ-018 rst or Next_Reg SHALL take priority over a same-cycle write or read, discarding any partially read wide word.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then one write of din = {beat7..beat0} with beat k = 128'hk repeated, then 8 back-to-back reads -> dout = 0,1,...,7 on successive cycles, each one cycle after its rd_en; empty=1 after the 8th read.
- 16 writes with no reads -> full=1; a 17th write is dropped; 128 reads return only the first 16 words in order.
- full=1, wr_en=1 on the same edge as the last-beat read of the head word -> write dropped, occupancy 15 after the edge.
- M_count=20, write 2 words then 1 more -> M_Ready=0 at narrow count 16; M_Ready=1 one cycle after narrow count reaches 24. S_count=3 -> S_Ready drops one cycle after occupancy reaches 3.
- 3 words written, 5 beats read, then Next_Reg pulse -> empty=1, dout=0 and narrow count 0 on the next cycle; a new write then reads back from beat 0.
- rd_en held high on an empty buffer for 10 cycles -> dout, pointers and beat index unchanged.
